rob_alloc_ctrl: RTL and testbench
=================================

Name: rob_alloc_ctrl

Overview:
- Pointer/occupancy controller for the reorder buffer.
- Allocates up to 2 ROB entries per cycle to the dispatch stage and tracks per-entry completion.
- Presents up to 2 in-order commit candidates per cycle and handles pipeline flush.
- Sits between rename/dispatch and the ROB entry storage; the storage array is indexed by the tags this block issues.

Parameters:
- ROB_DEPTH, 16, number of ROB entries; power of 2, min 4.
- TAG_W, $clog2(ROB_DEPTH), width of entry tag/index.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- disp_req  in  2  dispatch request per slot; slot1 honoured only with slot0
- disp_grant  out  2  allocation granted per slot (combinational)
- disp_tag0  out  TAG_W  tag for slot0 (= tail)
- disp_tag1  out  TAG_W  tag for slot1 (= tail+1 mod depth)
- done_valid  in  2  execution-complete strobes
- done_tag0  in  TAG_W  tag completed on port 0
- done_tag1  in  TAG_W  tag completed on port 1
- commit_stall  in  1  downstream cannot retire this cycle
- commit_valid  out  2  in-order commit per slot (combinational)
- commit_tag0  out  TAG_W  = head
- commit_tag1  out  TAG_W  = head+1 mod depth
- flush  in  1  discard all entries
- count  out  TAG_W+1  occupied entries (registered)
- full  out  1  count == ROB_DEPTH
- empty  out  1  count == 0

Behaviour:
- State: head, tail (TAG_W+1 bits each, MSB is wrap bit), valid[] and ready[] bit vectors, FSM {RUN, FLUSH}.
- Reset: head=tail=0, valid=ready=0, FSM=RUN.
- Reset outputs: count=0, empty=1, full=0, disp_grant=0, commit_valid=0.
- count = tail - head (TAG_W+1-bit subtraction); free = ROB_DEPTH - count.
- Dispatch:
  - n = popcount of effective requests; disp_req=2'b10 is treated as 2'b00.
  - All-or-nothing: disp_grant = effective req iff FSM==RUN, flush=0 and free >= n; otherwise 0.
  - Granted entries set valid=1, ready=0 at the next edge; tail advances by n.
  - free uses registered count only; entries committed this cycle are not reusable until next cycle.
- Completion:
  - done on a valid entry sets ready=1 next edge.
  - done on an invalid entry is ignored.
  - Both ports on the same tag: single set.
- Commit:
  - commit_valid[0] = valid[head] & ready[head] & ~commit_stall & ~flush & FSM==RUN.
  - commit_valid[1] = commit_valid[0] & valid[head+1] & ready[head+1].
  - Committed entries clear valid and ready; head advances by popcount.
  - Done and commit in the same cycle on head: entry commits next cycle (no bypass).
- Simultaneous dispatch and commit: both applied; count' = count + n_disp - n_commit.
- Wrap-around: index = low TAG_W bits; full is distinguished from empty by the wrap bit.
- Flush:
  - flush=1 forces disp_grant=0 and commit_valid=0 in the same cycle.
  - Next edge: valid=ready=0, head=tail=0, FSM=FLUSH; done inputs that cycle are ignored.
  - FLUSH lasts exactly 1 cycle with dispatch and commit blocked, then returns to RUN.
  - flush asserted while in FLUSH re-enters FLUSH.
- Reset mid-operation: identical to the reset state, overrides everything.

Optional Feature:
- Macro ROB_ALLOC_PERF_EN.
- Defined: adds outputs perf_commit_cnt (32, total committed instructions) and perf_full_stall_cnt (32, cycles with any effective disp_req and disp_grant=0 while FSM==RUN and flush=0). Both saturate at 2^32-1, are cleared by rst, and are not cleared by flush.
- Undefined: ports and counters absent.

Test Plan:
- Reset, then dispatch 2'b11 for 8 cycles -> tags (0,1),(2,3)...(14,15); count=16, full=1; next req 2'b01 -> grant 0.
- count=15, req 2'b11 -> grant 2'b00; req 2'b01 -> grant 2'b01, tag0=15.
- Dispatch tags 0..3; done tags 1,0; next cycle -> commit_valid=2'b11, tags 0,1. Done tag 3 only -> no commit until tag 2 done.
- Fill to 14, commit 2 and dispatch 2 in the same cycle -> count stays 14; tail wraps to index 0 with wrap bit set; empty/full correct across the wrap.
- Flush with 10 entries, done_valid and disp_req active -> grant=0 and commit=0 that cycle; next cycle count=0, FSM=FLUSH, grant=0; following cycle dispatch gets tags 0,1.
- commit_stall=1 with head ready -> commit_valid=0, head unchanged; release -> commits. With ROB_ALLOC_PERF_EN, perf_commit_cnt matches the commit total.

Source files
------------

// File: rtl/rob_alloc_ctrl.sv
// Reorder-buffer pointer/occupancy controller: dual-slot allocation, completion tracking,
// dual in-order commit and flush. Define ROB_ALLOC_PERF_EN to add the performance counters.
module rob_alloc_ctrl #(
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       disp_req,
    output logic [1:0]       disp_grant,
    output logic [TAG_W-1:0] disp_tag0,
    output logic [TAG_W-1:0] disp_tag1,
    input  logic [1:0]       done_valid,
    input  logic [TAG_W-1:0] done_tag0,
    input  logic [TAG_W-1:0] done_tag1,
    input  logic             commit_stall,
    output logic [1:0]       commit_valid,
    output logic [TAG_W-1:0] commit_tag0,
    output logic [TAG_W-1:0] commit_tag1,
    input  logic             flush,
    output logic [TAG_W:0]   count,
    output logic             full,
    output logic             empty
`ifdef ROB_ALLOC_PERF_EN
    ,
    output logic [31:0]      perf_commit_cnt,
    output logic [31:0]      perf_full_stall_cnt
`endif
);

    localparam int unsigned PTR_W = TAG_W + 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [ROB_DEPTH-1:0] valid_q, valid_d;
    logic [ROB_DEPTH-1:0] ready_q, ready_d;

    logic [TAG_W-1:0]     head_idx, head_idx1, tail_idx, tail_idx1;
    logic [PTR_W-1:0]     free_cnt;
    logic [1:0]           eff_req;
    logic [1:0]           n_req, n_grant, n_commit;
    logic                 run_ok;

    assign head_idx  = head_q[TAG_W-1:0];
    assign head_idx1 = head_idx + TAG_W'(1);
    assign tail_idx  = tail_q[TAG_W-1:0];
    assign tail_idx1 = tail_idx + TAG_W'(1);

    assign count    = tail_q - head_q;
    assign full     = (count == PTR_W'(ROB_DEPTH));
    assign empty    = (count == '0);
    assign free_cnt = PTR_W'(ROB_DEPTH) - count;

    // A lone slot-1 request has no slot-0 partner and is dropped entirely.
    assign eff_req = disp_req[0] ? disp_req : 2'b00;
    assign n_req   = {1'b0, eff_req[0]} + {1'b0, eff_req[1]};
    assign run_ok  = !rst && (state_q == RUN) && !flush;

    assign disp_grant = (run_ok && (free_cnt >= PTR_W'(n_req))) ? eff_req : 2'b00;
    assign disp_tag0  = tail_idx;
    assign disp_tag1  = tail_idx1;
    assign n_grant    = {1'b0, disp_grant[0]} + {1'b0, disp_grant[1]};

    assign commit_valid[0] = run_ok && !commit_stall && valid_q[head_idx] && ready_q[head_idx];
    assign commit_valid[1] = commit_valid[0] && valid_q[head_idx1] && ready_q[head_idx1];
    assign commit_tag0     = head_idx;
    assign commit_tag1     = head_idx1;
    assign n_commit        = {1'b0, commit_valid[0]} + {1'b0, commit_valid[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            ready_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        ready_d = ready_q;
        if (flush) begin
            state_d = FLUSH;
            head_d  = '0;
            tail_d  = '0;
            valid_d = '0;
            ready_d = '0;
        end else begin
            state_d = RUN;
            // Completion reads the pre-edge valid bits, so a done aimed at a slot
            // being allocated this cycle is dropped.
            if (done_valid[0] && valid_q[done_tag0]) ready_d[done_tag0] = 1'b1;
            if (done_valid[1] && valid_q[done_tag1]) ready_d[done_tag1] = 1'b1;
            if (commit_valid[0]) begin
                valid_d[head_idx] = 1'b0;
                ready_d[head_idx] = 1'b0;
            end
            if (commit_valid[1]) begin
                valid_d[head_idx1] = 1'b0;
                ready_d[head_idx1] = 1'b0;
            end
            if (disp_grant[0]) begin
                valid_d[tail_idx] = 1'b1;
                ready_d[tail_idx] = 1'b0;
            end
            if (disp_grant[1]) begin
                valid_d[tail_idx1] = 1'b1;
                ready_d[tail_idx1] = 1'b0;
            end
            head_d = head_q + PTR_W'(n_commit);
            tail_d = tail_q + PTR_W'(n_grant);
        end
    end

`ifdef ROB_ALLOC_PERF_EN
    logic stall_evt;
    assign stall_evt = (state_q == RUN) && !flush && (eff_req != 2'b00) && (disp_grant == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_commit_cnt     <= '0;
            perf_full_stall_cnt <= '0;
        end else begin
            if (perf_commit_cnt > (32'hFFFF_FFFF - 32'(n_commit)))
                perf_commit_cnt <= '1;
            else
                perf_commit_cnt <= perf_commit_cnt + 32'(n_commit);
            if (stall_evt && (perf_full_stall_cnt != '1))
                perf_full_stall_cnt <= perf_full_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Self-checking bench for rob_alloc_ctrl: table-driven vectors through a scoreboard queue,
// plus hand-written multi-cycle sequences for completion, wrap, flush and stall.
module tb_rob_alloc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] disp_req, disp_grant, done_valid, commit_valid;
    logic [3:0] disp_tag0, disp_tag1, done_tag0, done_tag1, commit_tag0, commit_tag1;
    logic       commit_stall, flush, full, empty;
    logic [4:0] count;
`ifdef ROB_ALLOC_PERF_EN
    logic [31:0] perf_commit_cnt, perf_full_stall_cnt;
`endif

    rob_alloc_ctrl #(.ROB_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_grant(disp_grant),
        .disp_tag0(disp_tag0), .disp_tag1(disp_tag1),
        .done_valid(done_valid), .done_tag0(done_tag0), .done_tag1(done_tag1),
        .commit_stall(commit_stall), .commit_valid(commit_valid),
        .commit_tag0(commit_tag0), .commit_tag1(commit_tag1),
        .flush(flush), .count(count), .full(full), .empty(empty)
`ifdef ROB_ALLOC_PERF_EN
        , .perf_commit_cnt(perf_commit_cnt), .perf_full_stall_cnt(perf_full_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [1:0] dv;
        logic [3:0] dt0;
        logic [3:0] dt1;
        logic       stall;
        logic       fl;
        logic [1:0] grant;
        logic [3:0] tag0;
        logic [3:0] tag1;
        logic [1:0] cv;
        logic [3:0] ctag0;
        logic [3:0] ctag1;
        logic [4:0] cnt;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[14];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step     = 0;
    int   exp_commits = 0;

    function automatic vec_t mk(input logic [1:0] req, input logic [1:0] dv,
                                input logic [3:0] dt0, input logic [3:0] dt1,
                                input logic stall, input logic fl,
                                input logic [1:0] grant, input logic [3:0] tag0,
                                input logic [3:0] tag1, input logic [1:0] cv,
                                input logic [3:0] ct0, input logic [3:0] ct1,
                                input logic [4:0] cnt);
        vec_t v;
        v.req = req; v.dv = dv; v.dt0 = dt0; v.dt1 = dt1; v.stall = stall; v.fl = fl;
        v.grant = grant; v.tag0 = tag0; v.tag1 = tag1; v.cv = cv;
        v.ctag0 = ct0; v.ctag1 = ct1; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        disp_req = v.req; done_valid = v.dv; done_tag0 = v.dt0; done_tag1 = v.dt1;
        commit_stall = v.stall; flush = v.fl;
        sb.push_back(v);
        #2;
        e = sb.pop_front();
        check("disp_grant", 32'(disp_grant), 32'(e.grant));
        check("commit_valid", 32'(commit_valid), 32'(e.cv));
        check("count", 32'(count), 32'(e.cnt));
        check("full", 32'(full), 32'(e.cnt == 5'd16));
        check("empty", 32'(empty), 32'(e.cnt == 5'd0));
        if (e.grant[0]) check("disp_tag0", 32'(disp_tag0), 32'(e.tag0));
        if (e.grant[1]) check("disp_tag1", 32'(disp_tag1), 32'(e.tag1));
        if (e.cv[0]) check("commit_tag0", 32'(commit_tag0), 32'(e.ctag0));
        if (e.cv[1]) check("commit_tag1", 32'(commit_tag1), 32'(e.ctag1));
        exp_commits += int'(e.cv[0]) + int'(e.cv[1]);
        step++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; disp_req = 2'b11; done_valid = 2'b00; flush = 1'b0; commit_stall = 1'b0;
        @(negedge clk);
        #2;
        check("rst_grant", 32'(disp_grant), 32'd0);
        check("rst_commit", 32'(commit_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        rst = 1'b0; disp_req = 2'b00;
        exp_commits = 0;
    endtask

    task automatic idle(input logic [1:0] cv, input logic [3:0] ct0, input logic [3:0] ct1,
                        input logic [4:0] cnt);
        apply(mk(2'b00, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, cv, ct0, ct1, cnt));
    endtask

    task automatic disp2(input int i);
        apply(mk(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b11, 4'(2*i), 4'(2*i+1),
                 2'b00, 4'd0, 4'd0, 5'(2*i)));
    endtask

    task automatic done2(input logic [3:0] t0, input logic [3:0] t1, input logic [4:0] cnt);
        apply(mk(2'b00, 2'b11, t0, t1, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, cnt));
    endtask

    initial begin
        rst = 1'b1; disp_req = '0; done_valid = '0; done_tag0 = '0; done_tag1 = '0;
        commit_stall = 1'b0; flush = 1'b0;

        // Fill to full, reject when full, commit one, then the count==15 boundary.
        for (int i = 0; i < 8; i++)
            tbl[i] = mk(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b11, 4'(2*i), 4'(2*i+1),
                        2'b00, 4'd0, 4'd0, 5'(2*i));
        tbl[8]  = mk(2'b01, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 5'd16);
        tbl[9]  = mk(2'b00, 2'b01, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 5'd16);
        tbl[10] = mk(2'b00, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 2'b01, 4'd0, 4'd0, 5'd16);
        tbl[11] = mk(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 5'd15);
        tbl[12] = mk(2'b01, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b01, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 5'd15);
        tbl[13] = mk(2'b00, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 5'd16);

        do_reset();
        for (int i = 0; i < 14; i++) apply(tbl[i]);

        // count==15 from a fresh start: tail sits at 15.
        do_reset();
        for (int i = 0; i < 7; i++) disp2(i);
        apply(mk(2'b01, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b01, 4'd14, 4'd0, 2'b00, 4'd0, 4'd0, 5'd14));
        apply(mk(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 5'd15));
        apply(mk(2'b01, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b01, 4'd15, 4'd0, 2'b00, 4'd0, 4'd0, 5'd15));
        idle(2'b00, 4'd0, 4'd0, 5'd16);

        // Out-of-order completion, in-order commit, no done->commit bypass.
        do_reset();
        apply(mk(2'b10, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 5'd0));
        disp2(0);
        disp2(1);
        done2(4'd1, 4'd0, 5'd4);
        idle(2'b11, 4'd0, 4'd1, 5'd4);
        apply(mk(2'b00, 2'b01, 4'd3, 4'd0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 5'd2));
        idle(2'b00, 4'd0, 4'd0, 5'd2);
        apply(mk(2'b00, 2'b01, 4'd2, 4'd0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 5'd2));
        idle(2'b11, 4'd2, 4'd3, 5'd2);
        // done on a not-yet-valid tag is dropped; both ports on one tag set it once
        apply(mk(2'b01, 2'b01, 4'd4, 4'd0, 1'b0, 1'b0, 2'b01, 4'd4, 4'd0, 2'b00, 4'd0, 4'd0, 5'd0));
        idle(2'b00, 4'd0, 4'd0, 5'd1);
        done2(4'd4, 4'd4, 5'd1);
        idle(2'b01, 4'd4, 4'd0, 5'd1);
        idle(2'b00, 4'd0, 4'd0, 5'd0);

        // Wrap-around with simultaneous dispatch and commit.
        do_reset();
        for (int i = 0; i < 7; i++) disp2(i);
        done2(4'd0, 4'd1, 5'd14);
        apply(mk(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b11, 4'd14, 4'd15, 2'b11, 4'd0, 4'd1, 5'd14));
        apply(mk(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b11, 4'd0, 4'd1, 2'b00, 4'd0, 4'd0, 5'd14));
        apply(mk(2'b01, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 5'd16));
        idle(2'b00, 4'd0, 4'd0, 5'd16);
`ifdef ROB_ALLOC_PERF_EN
        check("perf_commit_cnt_wrap", perf_commit_cnt, 32'(exp_commits));
        check("perf_full_stall_cnt_wrap", perf_full_stall_cnt, 32'd1);
`endif

        // Flush with work in flight, re-flush while flushing, then restart at tag 0.
        do_reset();
        for (int i = 0; i < 5; i++) disp2(i);
        done2(4'd0, 4'd1, 5'd10);
        apply(mk(2'b11, 2'b11, 4'd2, 4'd3, 1'b0, 1'b1, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 5'd10));
        apply(mk(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 1'b1, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 5'd0));
        apply(mk(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 5'd0));
        apply(mk(2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b11, 4'd0, 4'd1, 2'b00, 4'd0, 4'd0, 5'd0));
        idle(2'b00, 4'd0, 4'd0, 5'd2);

        // Commit stall holds the head until released.
        done2(4'd0, 4'd1, 5'd2);
        apply(mk(2'b00, 2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 5'd2));
        apply(mk(2'b00, 2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 5'd2));
        idle(2'b11, 4'd0, 4'd1, 5'd2);
        idle(2'b00, 4'd0, 4'd0, 5'd0);
`ifdef ROB_ALLOC_PERF_EN
        check("perf_commit_cnt_end", perf_commit_cnt, 32'(exp_commits));
        check("perf_full_stall_cnt_end", perf_full_stall_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
